// File: rtl/sub_pkg.sv
// sub_pkg: shared state encoding for the bit-serial subtractor controller
package sub_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/fullSubtractor.sv
// fullSubtractor: single-bit combinational a - b - bo_in cell
module fullSubtractor (
  input  logic a,
  input  logic b,
  input  logic bo_in,
  output logic diff,
  output logic bo_out
);
  assign diff   = a ^ b ^ bo_in;
  assign bo_out = (~a & b) | (~(a ^ b) & bo_in);
endmodule

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: LSB-first bit-serial WIDTH-bit subtractor, one bit per clock
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  import sub_pkg::*;
  localparam int CW = $clog2(WIDTH) + 1;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_sh_q, res_sh_d, diff_q, diff_d;
  logic             brw_q, brw_d, bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             d, bo, accept, last;
  fullSubtractor u_fs (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .bo_in (brw_q),
    .diff  (d),
    .bo_out(bo)
  );
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    diff_d   = diff_q;
    brw_d    = brw_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;
    accept   = start && (state_q == ST_IDLE || state_q == ST_DONE);
    last     = cnt_q == CW'(WIDTH - 1);
    if (accept) begin
      a_sh_d  = a;
      b_sh_d  = b;
      brw_d   = bin;
      cnt_d   = '0;
      state_d = ST_RUN;
    end else if (state_q == ST_RUN) begin
      a_sh_d   = a_sh_q >> 1;
      b_sh_d   = b_sh_q >> 1;
      res_sh_d = WIDTH'({d, res_sh_q} >> 1);
      brw_d    = bo;
      cnt_d    = cnt_q + CW'(1);
      if (last) begin
        diff_d  = res_sh_d;
        bout_d  = bo;
        state_d = ST_DONE;
      end
    end else begin
      // DONE without a new request, and the unused encoding, both fall back to IDLE
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      diff_q   <= '0;
      brw_q    <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      diff_q   <= diff_d;
      brw_q    <= brw_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
    end
  end
  assign busy = state_q == ST_RUN;
  assign done = state_q == ST_DONE;
  assign diff = diff_q;
  assign bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb_serial_subtractor_ctrl: directed checks at WIDTH=8 plus random scoreboards at WIDTH=1, 8, 13
module tb_serial_subtractor_ctrl;
  logic       clk, rst, rst_g, start, bin, busy, done, bout;
  logic [7:0] a, b, diff;
  int         n_tests = 0;
  int         n_fail  = 0;
  serial_subtractor_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask
  for (genvar g = 0; g < 3; g++) begin : g_r
    localparam int W = (g == 0) ? 1 : ((g == 1) ? 8 : 13);
    logic         st, rbi, rbo, rbusy, rdone, fin;
    logic [W-1:0] ra, rb, rd;
    logic [W:0]   want;
    int           c;
    serial_subtractor_ctrl #(.WIDTH(W)) u (
      .clk(clk), .rst(rst_g), .start(st), .a(ra), .b(rb), .bin(rbi),
      .busy(rbusy), .done(rdone), .diff(rd), .bout(rbo)
    );
    initial begin
      fin = 1'b0; st = 1'b0; ra = '0; rb = '0; rbi = 1'b0;
      repeat (6) @(negedge clk);
      for (int n = 0; n < 1000; n++) begin
        ra   = W'($urandom);
        rb   = W'($urandom);
        rbi  = 1'($urandom);
        st   = 1'b1;
        want = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbi};
        @(negedge clk);
        st = 1'b0;
        c  = 0;
        while (!rdone && c < W + 5) begin
          @(negedge clk);
          c++;
        end
        check($sformatf("rand_w%0d", W), 32'({rbo, rd}), 32'(want));
      end
      fin = 1'b1;
    end
  end
  initial begin
    rst_g = 1'b1;
    repeat (3) @(negedge clk);
    rst_g = 1'b0;
  end
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                        output int lat, output int nbusy);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb; bin = tbin;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    nbusy = int'(busy);
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      nbusy += int'(busy);
    end
  endtask
  initial begin
    int lat, nb, ndone;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", {busy, done, bout, diff}, 11'h000);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outs", {busy, done, bout, diff}, 11'h000);
    run_op(8'd5, 8'd3, 1'b0, lat, nb);
    check("5m3_res", {bout, diff}, 9'h002);
    check("5m3_lat", lat, 8);
    check("5m3_busy", nb, 8);
    @(negedge clk);
    check("done_pulse", {busy, done}, 2'b00);
    check("held_idle", {bout, diff}, 9'h002);
    run_op(8'd3, 8'd5, 1'b0, lat, nb);
    check("3m5_res", {bout, diff}, 9'h1FE);
    check("3m5_lat", lat, 8);
    run_op(8'd0, 8'd0, 1'b1, lat, nb);
    check("0m0b_res", {bout, diff}, 9'h1FF);
    run_op(8'hFF, 8'hFF, 1'b1, lat, nb);
    check("ffmffb_res", {bout, diff}, 9'h1FF);
    // start pulsed mid-RUN with new operands must be ignored
    @(negedge clk);
    start = 1'b1; a = 8'd5; b = 8'd3; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("run_held_diff", {bout, diff}, 9'h1FF);
    start = 1'b1; a = 8'hFF; b = 8'h01; bin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ndone += int'(done);
    end
    check("ign_ndone", ndone, 1);
    check("ign_res", {bout, diff}, 9'h002);
    // reset during the 4th RUN cycle aborts
    @(negedge clk);
    start = 1'b1; a = 8'd3; b = 8'd5; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_run_outs", {busy, done, bout, diff}, 11'h000);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      ndone += int'(done);
    end
    check("rst_no_done", ndone, 0);
    // start held high through DONE: back-to-back ops
    @(negedge clk);
    start = 1'b1; a = 8'd5; b = 8'd3; bin = 1'b0;
    @(negedge clk);
    a = 8'd3; b = 8'd5;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_first", {bout, diff}, 9'h002);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 1'b0;
    end while (!done && lat < 40);
    check("b2b_gap", lat, 9);
    check("b2b_second", {bout, diff}, 9'h1FE);
    for (int i = 0; i < 60000 && !(g_r[0].fin && g_r[1].fin && g_r[2].fin); i++) @(negedge clk);
    check("rand_done", {g_r[0].fin, g_r[1].fin, g_r[2].fin}, 3'b111);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
